// File: rtl/drive_pkg.sv
// Shared types, wheel codes and op decoding for the drive sequencer.
`timescale 1ns/1ps
package drive_pkg;

    typedef enum logic [2:0] {
        OP_STOP  = 3'd0,
        OP_FWD   = 3'd1,
        OP_BACK  = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4
    } drive_op_t;

    localparam logic [1:0] W_FWD  = 2'b01;
    localparam logic [1:0] W_STOP = 2'b11;
    localparam logic [1:0] W_BACK = 2'b10;

    typedef enum logic [1:0] {IDLE, DWELL, RUN} seq_state_t;

    // Returns {left, right}; undefined opcodes fall back to STOP.
    function automatic logic [3:0] op_to_codes(input logic [2:0] op);
        case (op)
            OP_FWD:   return {W_FWD,  W_FWD};
            OP_BACK:  return {W_BACK, W_BACK};
            OP_LEFT:  return {W_BACK, W_FWD};
            OP_RIGHT: return {W_FWD,  W_BACK};
            default:  return {W_STOP, W_STOP};
        endcase
    endfunction

    function automatic logic is_reversal(input logic [1:0] cur, input logic [1:0] nxt);
        return (cur == W_FWD && nxt == W_BACK) || (cur == W_BACK && nxt == W_FWD);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and a synchronous flush.
`timescale 1ns/1ps
module cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/drive_sequencer.sv
// Two-wheel drive command sequencer: frame-aligned code updates with reversal dwell.
// Optional emergency stop input enabled by defining DRIVE_SEQUENCER_ESTOP_EN.
`timescale 1ns/1ps
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int FRAME_CYCLES = 3072,
    parameter int DWELL_FRAMES = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DRIVE_SEQUENCER_ESTOP_EN
    input  logic        estop,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_dur,
    output logic [1:0]  instr_l,
    output logic [1:0]  instr_r,
    output logic        busy,
    output logic        done,
    output logic        frame_tick
);
    localparam int                CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [7:0]        DWELL_LD = 8'(DWELL_FRAMES);

    logic [CNT_W-1:0] count;
    seq_state_t       state;
    logic [7:0]       dwell_cnt;
    logic [15:0]      frames_left;
    logic [3:0]       held_codes;
    logic [15:0]      held_frames;

    logic        flush;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [18:0] head;
    logic [3:0]  head_codes;
    logic [15:0] head_frames;
    logic        head_rev;
    logic        last_frame;

`ifdef DRIVE_SEQUENCER_ESTOP_EN
    assign flush     = estop;
    assign cmd_ready = !full && !estop;
`else
    assign flush     = 1'b0;
    assign cmd_ready = !full;
`endif

    assign push = cmd_valid && cmd_ready;

    cmd_fifo #(.WIDTH(19), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .wr_en   (push),
        .wr_data ({cmd_op, cmd_dur}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (frame_tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign frame_tick = (count == CNT_LAST);

    // Reversal is judged against the codes currently driven, so a STOP in between clears it.
    assign head_codes  = op_to_codes(head[18:16]);
    assign head_frames = (head[15:0] == 16'd0) ? 16'd1 : head[15:0];
    assign head_rev    = is_reversal(instr_l, head_codes[3:2]) || is_reversal(instr_r, head_codes[1:0]);
    assign last_frame  = (state == RUN) && (frames_left == 16'd1);
    assign pop         = frame_tick && !empty && !flush && ((state == IDLE) || last_frame);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instr_l     <= W_STOP;
            instr_r     <= W_STOP;
            done        <= 1'b0;
            dwell_cnt   <= '0;
            frames_left <= '0;
            held_codes  <= {W_STOP, W_STOP};
            held_frames <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                instr_l <= W_STOP;
                instr_r <= W_STOP;
            end else if (frame_tick) begin
                done <= last_frame;
                if (pop) begin
                    held_codes  <= head_codes;
                    held_frames <= head_frames;
                    if (head_rev) begin
                        state     <= DWELL;
                        dwell_cnt <= DWELL_LD;
                        instr_l   <= W_STOP;
                        instr_r   <= W_STOP;
                    end else begin
                        state       <= RUN;
                        frames_left <= head_frames;
                        instr_l     <= head_codes[3:2];
                        instr_r     <= head_codes[1:0];
                    end
                end else begin
                    case (state)
                        DWELL: begin
                            if (dwell_cnt == 8'd1) begin
                                state       <= RUN;
                                frames_left <= held_frames;
                                instr_l     <= held_codes[3:2];
                                instr_r     <= held_codes[1:0];
                            end else begin
                                dwell_cnt <= dwell_cnt - 1'b1;
                            end
                        end
                        RUN: begin
                            if (frames_left == 16'd1) begin
                                state   <= IDLE;
                                instr_l <= W_STOP;
                                instr_r <= W_STOP;
                            end else begin
                                frames_left <= frames_left - 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with an 8-cycle frame and 2-frame dwell.
`timescale 1ns/1ps
module tb_drive_sequencer;
    import drive_pkg::*;

    localparam int FC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_dur;
    logic [1:0]  instr_l;
    logic [1:0]  instr_r;
    logic        busy;
    logic        done;
    logic        frame_tick;
`ifdef DRIVE_SEQUENCER_ESTOP_EN
    logic        estop;
`endif

    int passed = 0;
    int total  = 0;

    drive_sequencer #(.FRAME_CYCLES(FC), .DWELL_FRAMES(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef DRIVE_SEQUENCER_ESTOP_EN
        .estop      (estop),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dur    (cmd_dur),
        .instr_l    (instr_l),
        .instr_r    (instr_r),
        .busy       (busy),
        .done       (done),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] dur;
        logic [1:0]  el;
        logic [1:0]  er;
        int          frames;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [2:0] op, input logic [15:0] dur);
        cmd_op    = op;
        cmd_dur   = dur;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Advance to the negedge of the first cycle of the next frame.
    task automatic sync();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 4 * FC) begin
            @(negedge clk);
            n++;
        end
        check("sync_tick", 32'(n < 4 * FC), 32'd1);
        @(negedge clk);
    endtask

    // Checks all 8 cycles of one frame: {instr_l, instr_r, done, frame_tick, busy}.
    task automatic run_frame(input string name, input logic [1:0] el, input logic [1:0] er,
                             input logic ed, input logic eb);
        for (int i = 0; i < FC; i++) begin
            if (i == 1) cmd_valid = 1'b0;
            check($sformatf("%s[%0d]", name, i),
                  32'({instr_l, instr_r, done, frame_tick, busy}),
                  32'({el, er, ed && (i == 0), (i == FC - 1), eb}));
            @(negedge clk);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"fwd3",   3'd1, 16'd3, 2'b01, 2'b01, 3};
        vecs[1] = '{"back1",  3'd2, 16'd1, 2'b10, 2'b10, 1};
        vecs[2] = '{"left2",  3'd3, 16'd2, 2'b10, 2'b01, 2};
        vecs[3] = '{"right1", 3'd4, 16'd1, 2'b01, 2'b10, 1};
        vecs[4] = '{"stop2",  3'd0, 16'd2, 2'b11, 2'b11, 2};
        vecs[5] = '{"op6",    3'd6, 16'd1, 2'b11, 2'b11, 1};
        vecs[6] = '{"dur0",   3'd1, 16'd0, 2'b01, 2'b01, 1};

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_dur   = '0;
`ifdef DRIVE_SEQUENCER_ESTOP_EN
        estop     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_state", 32'({instr_l, instr_r, cmd_ready, busy, done, frame_tick}),
              32'({2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0}));
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_no_tick", 32'(frame_tick), 32'd0);
        sync();
        run_frame("idle_a", 2'b11, 2'b11, 1'b0, 1'b0);
        run_frame("idle_b", 2'b11, 2'b11, 1'b0, 1'b0);

        // Single commands from idle.
        for (int v = 0; v < 7; v++) begin
            push(vecs[v].op, vecs[v].dur);
            check({vecs[v].name, "_queued"}, 32'({instr_l, instr_r, busy}), 32'({4'b1111, 1'b1}));
            sync();
            for (int f = 0; f < vecs[v].frames; f++)
                run_frame($sformatf("%s_f%0d", vecs[v].name, f), vecs[v].el, vecs[v].er, 1'b0, 1'b1);
            run_frame({vecs[v].name, "_end"}, 2'b11, 2'b11, 1'b1, 1'b0);
        end

        // FWD 2 then BACK 1: reversal inserts two stop frames.
        push(3'd1, 16'd2);
        push(3'd2, 16'd1);
        sync();
        run_frame("rev_fwd0", 2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("rev_fwd1", 2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("rev_dw0",  2'b11, 2'b11, 1'b1, 1'b1);
        run_frame("rev_dw1",  2'b11, 2'b11, 1'b0, 1'b1);
        run_frame("rev_back", 2'b10, 2'b10, 1'b0, 1'b1);
        run_frame("rev_end",  2'b11, 2'b11, 1'b1, 1'b0);

        // LEFT then RIGHT: both wheels reverse.
        push(3'd3, 16'd1);
        push(3'd4, 16'd1);
        sync();
        run_frame("lr_left",  2'b10, 2'b01, 1'b0, 1'b1);
        run_frame("lr_dw0",   2'b11, 2'b11, 1'b1, 1'b1);
        run_frame("lr_dw1",   2'b11, 2'b11, 1'b0, 1'b1);
        run_frame("lr_right", 2'b01, 2'b10, 1'b0, 1'b1);
        run_frame("lr_end",   2'b11, 2'b11, 1'b1, 1'b0);

        // FWD, STOP, BACK: the stop clears the reversal, no dwell.
        push(3'd1, 16'd1);
        push(3'd0, 16'd1);
        push(3'd2, 16'd1);
        sync();
        run_frame("fsb_fwd",  2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("fsb_stop", 2'b11, 2'b11, 1'b1, 1'b1);
        run_frame("fsb_back", 2'b10, 2'b10, 1'b1, 1'b1);
        run_frame("fsb_end",  2'b11, 2'b11, 1'b1, 1'b0);

        // Five commands back-to-back: the fifth waits for the first pop.
        cmd_valid = 1'b1;
        cmd_op = 3'd1; cmd_dur = 16'd1;
        check("fill_ready0", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_op = 3'd0; cmd_dur = 16'd2;
        @(negedge clk);
        cmd_op = 3'd3; cmd_dur = 16'd1;
        @(negedge clk);
        cmd_op = 3'd0; cmd_dur = 16'd1;
        @(negedge clk);
        cmd_op = 3'd4; cmd_dur = 16'd2;
        for (int k = 4; k < FC; k++) begin
            check($sformatf("fill_full_c%0d", k), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check("fill_ready_after_pop", 32'(cmd_ready), 32'd1);
        run_frame("q_fwd",   2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("q_stop0", 2'b11, 2'b11, 1'b1, 1'b1);
        run_frame("q_stop1", 2'b11, 2'b11, 1'b0, 1'b1);
        run_frame("q_left",  2'b10, 2'b01, 1'b1, 1'b1);
        run_frame("q_stop",  2'b11, 2'b11, 1'b1, 1'b1);
        run_frame("q_right0", 2'b01, 2'b10, 1'b1, 1'b1);
        run_frame("q_right1", 2'b01, 2'b10, 1'b0, 1'b1);
        run_frame("q_end",   2'b11, 2'b11, 1'b1, 1'b0);

        // A push in the tick cycle misses that tick.
        repeat (FC - 1) @(negedge clk);
        push(3'd1, 16'd1);
        run_frame("late_wait", 2'b11, 2'b11, 1'b0, 1'b1);
        run_frame("late_fwd",  2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("late_end",  2'b11, 2'b11, 1'b1, 1'b0);

        // Asynchronous reset mid-command discards the FIFO.
        push(3'd1, 16'd5);
        push(3'd2, 16'd1);
        sync();
        run_frame("rst_fwd", 2'b01, 2'b01, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1 check("rst_async", 32'({instr_l, instr_r, cmd_ready, busy, done}), 32'({4'b1111, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        reset = 1'b1;
        sync();
        run_frame("rst_idle", 2'b11, 2'b11, 1'b0, 1'b0);

`ifdef DRIVE_SEQUENCER_ESTOP_EN
        push(3'd1, 16'd10);
        push(3'd2, 16'd1);
        sync();
        run_frame("es_fwd0", 2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("es_fwd1", 2'b01, 2'b01, 1'b0, 1'b1);
        estop = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("es_hold%0d", k), 32'({instr_l, instr_r, busy, cmd_ready, done}), 32'({4'b1111, 3'b000}));
            @(negedge clk);
        end
        estop = 1'b0;
        sync();
        run_frame("es_idle", 2'b11, 2'b11, 1'b0, 1'b0);
        push(3'd1, 16'd1);
        sync();
        run_frame("es_new", 2'b01, 2'b01, 1'b0, 1'b1);
        run_frame("es_end", 2'b11, 2'b11, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Command sequencer for the two wheel servo channels of the robot drive train. Accepts high-level drive commands (op plus duration in PWM frames) through a valid/ready port and buffers them in a small FIFO. Executes them back-to-back, producing the 2-bit per-wheel instruction codes consumed by the per-wheel PWM motor drivers. Enforces a stop dwell before any wheel reverses direction, and updates instructions only on PWM frame boundaries.

## Interface
- FRAME_CYCLES, 3072: clk cycles per PWM frame; must match the motor driver period.
- DWELL_FRAMES, 4: frames of forced stop inserted before a direction reversal; legal range 1..255.
- FIFO_DEPTH, 4: command FIFO entries; power of two, minimum 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a command transfers on a rising edge with cmd_valid && cmd_ready.
- cmd_op  in  3  0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT; 5..7 are treated as STOP.
- cmd_dur  in  16  duration in frames; 0 is treated as 1.
- instr_l  out  2  left wheel code: 01 forward, 11 stop, 10 back.
- instr_r  out  2  right wheel code, same encoding.
- busy  out  1  state != IDLE or FIFO non-empty.
- done  out  1  one-cycle pulse when a command's last frame ends.
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- Frame counter runs 0..FRAME_CYCLES-1 and wraps. frame_tick = (count == FRAME_CYCLES-1).
- State, instr_l/instr_r and the duration counters update only on the edge that ends a frame_tick cycle.
- Op mapping to (left, right): STOP (11,11), FWD (01,01), BACK (10,10), LEFT (10,01), RIGHT (01,10).
- Reversal: a wheel whose current output is 01 and new code is 10, or the reverse. Transitions through 11 are not reversals.
- IDLE: outputs 11/11. On tick with FIFO non-empty, pop the head.
  - If the head causes a reversal, go to DWELL. Otherwise go to RUN with the head's codes applied.
- DWELL: outputs 11/11, dwell_cnt loaded with DWELL_FRAMES. Decrement on each tick. On the tick where dwell_cnt==1, go to RUN and apply the held command's codes.
- RUN: frames_left loaded with max(cmd_dur,1). Decrement on each tick. On the tick where frames_left==1:
  - Pulse done.
  - If the FIFO is non-empty, pop the next command with the same reversal check against current outputs. This goes straight to RUN or DWELL with no idle frame.
  - If the FIFO is empty, go to IDLE with outputs 11/11.
- STOP commands run in RUN with outputs 11/11. A subsequent opposite-direction command needs no extra dwell.
- FIFO: push on cmd_valid && cmd_ready; pop as above. Push and pop in the same cycle are both honoured. Occupancy is unchanged when both happen.
- Reset mid-operation: asynchronous return to reset values. The FIFO is emptied and any in-flight command is discarded.

## Timing
- Reset values:
  - instr_l = instr_r = 2'b11.
  - cmd_ready = 1, busy = 0, done = 0, frame_tick = 0.
  - Frame count 0, state IDLE.
- A command written on edge t is eligible from the first frame_tick cycle after t. A push in a tick cycle misses that tick.
- Worst-case latency from acceptance to applied codes is FRAME_CYCLES+1 cycles, plus DWELL_FRAMES·FRAME_CYCLES if a reversal occurs.
- Outputs are registered and change only on tick edges. Each code is held for exactly cmd_dur frames.
- done is asserted in the cycle following the final tick edge.

## Configuration
- DRIVE_SEQUENCER_ESTOP_EN defined: adds input estop (1 bit, synchronous, level).
  - While estop is high: outputs are 11/11 from the next edge, regardless of tick. The FIFO is flushed, the state is IDLE, cmd_ready=0, and done is suppressed.
  - After estop falls, resume in IDLE on the next tick.
- DRIVE_SEQUENCER_ESTOP_EN not defined: no estop port and no flush logic.

## Structure
- Package drive_pkg holds:
  - drive_op_t enum.
  - Wheel code localparams: W_FWD 2'b01, W_STOP 2'b11, W_BACK 2'b10.
  - seq_state_t {IDLE, DWELL, RUN}.
  - Function op_to_codes returning the {left, right} pair.
- Sub-module cmd_fifo: synchronous FIFO, 19-bit wide, FIFO_DEPTH deep, with full/empty flags and an async active-low reset.
- Frame counter, FSM and duration counters are in the top level.

## Test plan
Bench parameters: FRAME_CYCLES=8, DWELL_FRAMES=2, FIFO_DEPTH=4.
- Reset, no commands: instr_l/instr_r=11 indefinitely; busy=0; frame_tick every 8 cycles.
- Push FWD dur 3: 01/01 for exactly 24 cycles starting at the first tick edge; then done pulse; then 11/11 and busy=0.
- FWD dur 2 then BACK dur 1: 01/01 for 2 frames, 11/11 for 2 frames, 10/10 for 1 frame. done pulses twice.
- LEFT dur 1, then RIGHT dur 1: 10/01, then 2 dwell frames, then 01/10. FWD→STOP→BACK inserts no dwell.
- Push 5 commands back-to-back while idle: cmd_ready falls after 4. The fifth transfers after the first pop. Commands execute with no gap frames.
- With DRIVE_SEQUENCER_ESTOP_EN: estop mid-FWD dur 10 → 11/11 next cycle, FIFO empty, no done. After release, a new command runs normally.
